traffic_phase_controller: RTL and testbench

- Consumer of the per-road vehicle counts (CountA..CountD) produced by the traffic counter.
- Runs a four-road signal cycle: GREEN → YELLOW → ALL_RED → next road.
- Green time scales with the queued-vehicle count of the served road; roads with empty queues are skipped.
- Drives the lamp outputs for roads A–D and is the sole authority on which road holds right-of-way.

---
 rtl/traffic_phase_controller_if.sv | 26 ++
 rtl/traffic_phase_controller.sv | 136 +++++++++++++
 tb/tb_traffic_phase_controller.sv | 274 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/traffic_phase_controller_if.sv
// Signal bundle between the traffic phase controller and its environment:
// timebase and queue counts in, lamp/phase status out.
interface traffic_phase_controller_if;
  logic       tick;
  logic [7:0] CountA;
  logic [7:0] CountB;
  logic [7:0] CountC;
  logic [7:0] CountD;
  logic [2:0] LightA;
  logic [2:0] LightB;
  logic [2:0] LightC;
  logic [2:0] LightD;
  logic [1:0] active_road;
  logic [1:0] phase;
  logic [7:0] timer;

  modport master (
    output tick, CountA, CountB, CountC, CountD,
    input  LightA, LightB, LightC, LightD, active_road, phase, timer
  );

  modport slave (
    input  tick, CountA, CountB, CountC, CountD,
    output LightA, LightB, LightC, LightD, active_road, phase, timer
  );
endinterface

// File: rtl/traffic_phase_controller.sv
// Four-road signal sequencer: ALL_RED -> SELECT -> GREEN -> YELLOW, with green time
// scaled by the served road's queue and early gap-out when that queue empties.
module traffic_phase_controller #(
  parameter int unsigned MIN_GREEN   = 5,
  parameter int unsigned MAX_GREEN   = 30,
  parameter int unsigned PER_CAR     = 2,
  parameter int unsigned YELLOW_TIME = 3,
  parameter int unsigned ALLRED_TIME = 1
) (
  input logic                         clk,
  input logic                         reset,
  traffic_phase_controller_if.slave   bus
);

  typedef enum logic [1:0] {
    StAllRed = 2'd0,
    StSelect = 2'd1,
    StGreen  = 2'd2,
    StYellow = 2'd3
  } phase_e;

  phase_e          phase_q, phase_d;
  logic [7:0]      timer_q, timer_d;
  logic [7:0]      elapsed_q, elapsed_d;
  logic [1:0]      road_q, road_d;
  logic [3:0][2:0] light_q, light_d;

  logic [3:0][7:0] counts;
  logic [1:0]      sel_road;
  logic [1:0]      cand;
  logic            found;
  logic [15:0]     green_raw;
  logic [7:0]      green_dur;
  logic [8:0]      elapsed_inc;
  logic            gap_out;

  assign counts = {bus.CountD, bus.CountC, bus.CountB, bus.CountA};

  // Cyclic scan from the road after the last served one; falls back to that next road.
  always_comb begin
    sel_road = road_q + 2'd1;
    found    = 1'b0;
    cand     = '0;
    for (int k = 1; k <= 4; k++) begin
      cand = road_q + 2'(k);
      if (!found && (counts[cand] != 8'd0)) begin
        sel_road = cand;
        found    = 1'b1;
      end
    end
  end

  assign green_raw   = 16'(MIN_GREEN) + 16'(counts[sel_road]) * 16'(PER_CAR);
  assign green_dur   = (green_raw > 16'(MAX_GREEN)) ? 8'(MAX_GREEN) : green_raw[7:0];
  assign elapsed_inc = {1'b0, elapsed_q} + 9'd1;
  assign gap_out     = (counts[road_q] == 8'd0) && (elapsed_inc >= 9'(MIN_GREEN));

  always_comb begin
    phase_d   = phase_q;
    timer_d   = timer_q;
    road_d    = road_q;
    elapsed_d = elapsed_q;
    unique case (phase_q)
      StAllRed: begin
        if (bus.tick) begin
          if (timer_q == 8'd1) phase_d = StSelect;
          else                 timer_d = timer_q - 8'd1;
        end
      end
      StSelect: begin
        road_d    = sel_road;
        timer_d   = green_dur;
        elapsed_d = '0;
        phase_d   = StGreen;
      end
      StGreen: begin
        if (bus.tick) begin
          elapsed_d = (elapsed_q == 8'hff) ? elapsed_q : elapsed_q + 8'd1;
          if (gap_out || (timer_q == 8'd1)) begin
            phase_d = StYellow;
            timer_d = 8'(YELLOW_TIME);
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      StYellow: begin
        if (bus.tick) begin
          if (timer_q == 8'd1) begin
            phase_d = StAllRed;
            timer_d = 8'(ALLRED_TIME);
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
      end
      default: ;
    endcase
  end

  // Lamps derive from the next state so they register in step with the phase.
  always_comb begin
    for (int r = 0; r < 4; r++) begin
      light_d[r] = 3'b100;
      if (2'(r) == road_d) begin
        if (phase_d == StGreen)       light_d[r] = 3'b001;
        else if (phase_d == StYellow) light_d[r] = 3'b010;
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q   <= StAllRed;
      timer_q   <= 8'(ALLRED_TIME);
      road_q    <= 2'd3;
      elapsed_q <= '0;
      light_q   <= {4{3'b100}};
    end else begin
      phase_q   <= phase_d;
      timer_q   <= timer_d;
      road_q    <= road_d;
      elapsed_q <= elapsed_d;
      light_q   <= light_d;
    end
  end

  assign bus.LightA      = light_q[0];
  assign bus.LightB      = light_q[1];
  assign bus.LightC      = light_q[2];
  assign bus.LightD      = light_q[3];
  assign bus.active_road = road_q;
  assign bus.phase       = phase_q;
  assign bus.timer       = timer_q;

endmodule

// File: tb/tb_traffic_phase_controller.sv
// Bench for traffic_phase_controller: directed scenarios plus randomized traffic,
// compared against a behavioural phase model and observed safety invariants.
module tb_traffic_phase_controller;
  localparam int MinGreen   = 5;
  localparam int MaxGreen   = 30;
  localparam int PerCar     = 2;
  localparam int YellowTime = 3;
  localparam int AllredTime = 1;

  localparam int PhAllRed = 0;
  localparam int PhSelect = 1;
  localparam int PhGreen  = 2;
  localparam int PhYellow = 3;

  logic clk = 1'b0;
  logic reset;

  traffic_phase_controller_if tpc_if ();

  traffic_phase_controller #(
    .MIN_GREEN  (MinGreen),
    .MAX_GREEN  (MaxGreen),
    .PER_CAR    (PerCar),
    .YELLOW_TIME(YellowTime),
    .ALLRED_TIME(AllredTime)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (tpc_if.slave)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_pass   = 0;

  int cnt[4];
  bit tk;

  int m_phase, m_timer, m_road, m_elapsed;

  int greens[$];
  int prev_phase;
  int yel_ticks;
  int red_ticks;

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
  endtask

  task automatic drive_inputs();
    tpc_if.tick   = tk;
    tpc_if.CountA = 8'(cnt[0]);
    tpc_if.CountB = 8'(cnt[1]);
    tpc_if.CountC = 8'(cnt[2]);
    tpc_if.CountD = 8'(cnt[3]);
  endtask

  task automatic model_reset();
    m_phase    = PhAllRed;
    m_timer    = AllredTime;
    m_road     = 3;
    m_elapsed  = 0;
    prev_phase = PhAllRed;
    yel_ticks  = 0;
    red_ticks  = 0;
  endtask

  // One clock of the phase rules, using the inputs the DUT samples at that edge.
  task automatic model_step();
    int sel, dur, e1;
    bit gap;
    case (m_phase)
      PhAllRed: if (tk) begin
        if (m_timer == 1) m_phase = PhSelect;
        else m_timer = m_timer - 1;
      end
      PhSelect: begin
        sel = -1;
        for (int k = 1; k <= 4; k++) begin
          if (sel < 0 && cnt[(m_road + k) % 4] != 0) sel = (m_road + k) % 4;
        end
        if (sel < 0) sel = (m_road + 1) % 4;
        dur = MinGreen + cnt[sel] * PerCar;
        if (dur > MaxGreen) dur = MaxGreen;
        m_road    = sel;
        m_timer   = dur;
        m_elapsed = 0;
        m_phase   = PhGreen;
      end
      PhGreen: if (tk) begin
        e1  = m_elapsed + 1;
        gap = (cnt[m_road] == 0) && (e1 >= MinGreen);
        m_elapsed = (e1 > 255) ? 255 : e1;
        if (gap || m_timer == 1) begin
          m_phase = PhYellow;
          m_timer = YellowTime;
        end else begin
          m_timer = m_timer - 1;
        end
      end
      default: if (tk) begin
        if (m_timer == 1) begin
          m_phase = PhAllRed;
          m_timer = AllredTime;
        end else begin
          m_timer = m_timer - 1;
        end
      end
    endcase
  endtask

  function automatic int exp_light(input int r);
    if (r == m_road && m_phase == PhGreen)  return 1;
    if (r == m_road && m_phase == PhYellow) return 2;
    return 4;
  endfunction

  task automatic compare_all();
    int lights[4];
    int nonred;
    int cur;
    lights[0] = int'(tpc_if.LightA);
    lights[1] = int'(tpc_if.LightB);
    lights[2] = int'(tpc_if.LightC);
    lights[3] = int'(tpc_if.LightD);
    check_eq("phase", int'(tpc_if.phase), m_phase);
    check_eq("timer", int'(tpc_if.timer), m_timer);
    check_eq("active_road", int'(tpc_if.active_road), m_road);
    nonred = 0;
    for (int r = 0; r < 4; r++) begin
      check_eq($sformatf("light%0d", r), lights[r], exp_light(r));
      if (lights[r] != 4) nonred++;
    end
    check_eq("one_nonred", int'(nonred <= 1), 1);
    // Sequencing invariants judged purely from observed phases.
    cur = int'(tpc_if.phase);
    if (prev_phase == PhYellow && tk) yel_ticks++;
    if (prev_phase == PhAllRed && tk) red_ticks++;
    if (cur != prev_phase) begin
      if (prev_phase == PhGreen) check_eq("green_to_yellow", cur, PhYellow);
      if (prev_phase == PhYellow) check_eq("yellow_len", yel_ticks, YellowTime);
      if (cur == PhYellow) yel_ticks = 0;
      if (cur == PhGreen) begin
        check_eq("allred_before_green", int'(red_ticks >= 1), 1);
        red_ticks = 0;
        greens.push_back(int'(tpc_if.active_road));
      end
    end
    prev_phase = cur;
  endtask

  task automatic step();
    drive_inputs();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  task automatic do_reset(input int a, input int b, input int c, input int d);
    reset = 1'b0;
    tk    = 1'b0;
    cnt[0] = a; cnt[1] = b; cnt[2] = c; cnt[3] = d;
    drive_inputs();
    model_reset();
    greens.delete();
    @(posedge clk);
    #1;
    compare_all();
    reset = 1'b1;
    tk    = 1'b1;
  endtask

  initial begin
    reset = 1'b0;
    tk    = 1'b0;
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    drive_inputs();
    repeat (2) @(posedge clk);
    #1;

    // All queues empty: plain round-robin A, B, C, D, A.
    do_reset(0, 0, 0, 0);
    repeat (55) step();
    check_eq("rr_green_count", int'(greens.size() >= 5), 1);
    for (int i = 0; i < 5 && i < greens.size(); i++)
      check_eq($sformatf("rr_order%0d", i), greens[i], i % 4);

    // Only C queued: A and B skipped, green 5 + 10*2 = 25 ticks.
    do_reset(0, 0, 10, 0);
    step();
    step();
    check_eq("c_phase", int'(tpc_if.phase), PhGreen);
    check_eq("c_road", int'(tpc_if.active_road), 2);
    check_eq("c_light", int'(tpc_if.LightC), 1);
    check_eq("c_timer", int'(tpc_if.timer), 25);
    repeat (24) step();
    check_eq("c_still_green", int'(tpc_if.phase), PhGreen);
    step();
    check_eq("c_yellow_after_25", int'(tpc_if.phase), PhYellow);

    // Large queue clamps to the maximum green.
    do_reset(200, 0, 0, 0);
    step();
    step();
    check_eq("clamp_road", int'(tpc_if.active_road), 0);
    check_eq("clamp_timer", int'(tpc_if.timer), 30);

    // Gap-out: B queue drains after 2 ticks, yellow on tick 5.
    do_reset(0, 10, 0, 0);
    step();
    step();
    check_eq("gap_road", int'(tpc_if.active_road), 1);
    check_eq("gap_timer", int'(tpc_if.timer), 25);
    step();
    step();
    cnt[1] = 0;
    step();
    step();
    check_eq("gap_green_tick4", int'(tpc_if.phase), PhGreen);
    step();
    check_eq("gap_yellow_tick5", int'(tpc_if.phase), PhYellow);

    // Asynchronous reset during B green.
    do_reset(0, 10, 0, 0);
    step();
    step();
    step();
    check_eq("pre_async_light_b", int'(tpc_if.LightB), 1);
    #3;
    reset = 1'b0;
    #1;
    check_eq("async_phase", int'(tpc_if.phase), PhAllRed);
    check_eq("async_light_a", int'(tpc_if.LightA), 4);
    check_eq("async_light_b", int'(tpc_if.LightB), 4);
    check_eq("async_light_c", int'(tpc_if.LightC), 4);
    check_eq("async_light_d", int'(tpc_if.LightD), 4);
    model_reset();
    greens.delete();
    for (int i = 0; i < 4; i++) cnt[i] = 0;
    tk = 1'b1;
    drive_inputs();
    #1;
    reset = 1'b1;
    step();
    step();
    check_eq("post_reset_phase", int'(tpc_if.phase), PhGreen);
    check_eq("post_reset_road", int'(tpc_if.active_road), 0);

    // Randomized traffic and tick gaps.
    do_reset(0, 0, 0, 0);
    for (int n = 0; n < 10000; n++) begin
      int r;
      tk = ($urandom_range(0, 2) != 0);
      if ($urandom_range(0, 19) == 0) begin
        r = $urandom_range(0, 3);
        case ($urandom_range(0, 3))
          0, 1:    cnt[r] = 0;
          2:       cnt[r] = $urandom_range(1, 15);
          default: cnt[r] = $urandom_range(16, 255);
        endcase
      end
      step();
    end
    check_eq("random_made_progress", int'(greens.size() > 10), 1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
